pixel_sensor_cds: RTL
=====================

PIXEL_SENSOR_CDS -- requirements
Module: pixel_sensor_cds

Interface
REQ-001 Parameter PIXEL_BITS, default 8: conversion and data width, 4..16.
REQ-002 Parameter WIDTH_INDEX, default 0: column position; drives no logic in this block.
REQ-003 Parameter HEIGHT_INDEX, default 0: row position; drives no logic in this block.
REQ-004 clk  in  1  single block clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ERASE  in  1  clear pixel, start new frame.
REQ-007 EXPOSE  in  1  integration window level.
REQ-008 CONVERT  in  1  ramp conversion window level.
REQ-009 READ  in  1  readout request for this pixel.
REQ-010 CMP  in  1  analog comparator output; 1 = ramp has crossed the pixel voltage.
REQ-011 COUNTER  in  PIXEL_BITS  global ramp code.
REQ-012 DATA  out  PIXEL_BITS  registered pixel value; 0 when not read (wired-OR friendly).
REQ-013 DATA_VALID  out  1  DATA holds a valid read result.
REQ-014 OVERFLOW  out  1  last conversion ended without a comparator trip.

Function
REQ-015 States: IDLE, ERASE, EXPOSE, CONV_RST, CONV_SIG, HOLD.
REQ-016 ERASE=1 in any state -> ERASE next cycle; clears both sample registers, OVERFLOW and DATA_VALID; ERASE has priority over all other inputs.
REQ-017 ERASE -> EXPOSE when ERASE=0 and EXPOSE=1; otherwise stays in ERASE.
REQ-018 EXPOSE -> CONV_RST (CDS build) or CONV_SIG (non-CDS build) when EXPOSE=0 and CONVERT=1.
REQ-019 In a conversion state, the first cycle with CMP=1 latches COUNTER into that state's sample register; later CMP=1 cycles in the same window are ignored.
REQ-020 CONV_RST -> CONV_SIG on CONVERT falling; the sample becomes the reset level. The next CONVERT rising edge starts the signal window.
REQ-021 CONV_SIG -> HOLD on CONVERT falling.
REQ-022 A window with no trip stores all-ones and sets OVERFLOW=1.
REQ-023 Result in HOLD: CDS build = sig - rst, clamped to 0 if negative; non-CDS build = sig.
REQ-024 Result arithmetic is done in PIXEL_BITS+1 bits and the final value is truncated to PIXEL_BITS.
REQ-025 READ=1 in HOLD -> DATA=result and DATA_VALID=1 on the next cycle; the latency is exactly 1 cycle.
REQ-026 READ=0 or state != HOLD -> DATA=0 and DATA_VALID=0 on the next cycle.
REQ-027 Reads are non-destructive; repeated READ in HOLD returns the same value.
REQ-028 EXPOSE and CONVERT both high in EXPOSE state -> remain in EXPOSE; CONVERT alone in IDLE or HOLD is ignored.
REQ-029 COUNTER wrap-around is not detected; the latched code is used as given.

Reset
REQ-030 reset=1 -> state IDLE, DATA=0, DATA_VALID=0, OVERFLOW=0, sample registers 0, on the next rising clk edge.
REQ-031 reset has priority over ERASE.
REQ-032 reset mid-conversion discards partial samples; no output pulses during or after reset.

Configuration
REQ-033 Macro PIXEL_SENSOR_CDS_EN defined -> CONV_RST state, reset-level register and subtractor are built.
REQ-034 Macro PIXEL_SENSOR_CDS_EN undefined -> CONV_RST and reset-level register are absent, EXPOSE goes directly to CONV_SIG, and result = sig.

Structure
REQ-035 Shared package PixelSensorConfig holds PIXEL_BITS default and the state enum type pixel_state_t.
REQ-036 One sub-module, pixel_sample_latch (first-trip capture, one per window), is instantiated twice in the CDS build and once otherwise.

Verification
REQ-037 PIXEL_BITS=8, CDS build; CMP trips at COUNTER=20 (reset window) and 150 (signal window); READ -> DATA=130, DATA_VALID=1 one cycle after READ, OVERFLOW=0.
REQ-038 Reset trip 200, signal trip 100 -> DATA=0 (clamped).
REQ-039 Signal window with no CMP trip -> OVERFLOW=1; non-CDS build returns DATA=255.
REQ-040 ERASE asserted mid-CONV_SIG -> ERASE state next cycle; a following READ gives DATA=0, DATA_VALID=0.
REQ-041 reset pulsed during CONV_RST -> IDLE; READ gives DATA=0; CMP pulses are ignored until the next ERASE.
REQ-042 CMP high for 5 cycles from COUNTER=40 -> latched value 40; three back-to-back READs each return 40 (CDS rst sample 0).

Source files
------------

// File: rtl/pixel_sensor_cds_pkg.sv
// Shared configuration for the pixel sensor block: default pixel width and
// the pixel control state encoding used by the top level and the bench.
package PixelSensorConfig;

    // Conversion and data width used when the instantiation does not override it
    localparam int PIXEL_BITS_DEFAULT = 8;

    // Supported range of PIXEL_BITS
    localparam int PIXEL_BITS_MIN = 4;
    localparam int PIXEL_BITS_MAX = 16;

    // Pixel control states; ST_CONV_RST is only reachable when the
    // correlated double sampling path is built
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ERASE    = 3'd1,
        ST_EXPOSE   = 3'd2,
        ST_CONV_RST = 3'd3,
        ST_CONV_SIG = 3'd4,
        ST_HOLD     = 3'd5
    } pixel_state_t;

endpackage

// File: rtl/pixel_sensor_cds_sample_latch.sv
// First-trip capture for one ramp conversion window.
// While the window is open the first comparator trip stores the ramp code;
// later trips in the same window are ignored. If the window closes without a
// trip the sample saturates to all-ones and no_trip is raised.
module pixel_sample_latch
    import PixelSensorConfig::*;
#(
    parameter int PIXEL_BITS = PIXEL_BITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  window_open,
    input  logic                  window_close,
    input  logic                  cmp,
    input  logic [PIXEL_BITS-1:0] counter,
    output logic [PIXEL_BITS-1:0] sample,
    output logic                  no_trip
);

    logic [PIXEL_BITS-1:0] sample_q;
    logic [PIXEL_BITS-1:0] sample_d;
    logic                  tripped_q;
    logic                  tripped_d;
    logic                  no_trip_q;
    logic                  no_trip_d;

    // Capture the first trip, or saturate when the window ends untripped
    always_comb begin
        sample_d  = sample_q;
        tripped_d = tripped_q;
        no_trip_d = no_trip_q;
        if (clear) begin
            sample_d  = '0;
            tripped_d = 1'b0;
            no_trip_d = 1'b0;
        end else if (window_open && cmp && !tripped_q) begin
            sample_d  = counter;
            tripped_d = 1'b1;
        end else if (window_close && !tripped_q) begin
            sample_d  = '1;
            tripped_d = 1'b1;
            no_trip_d = 1'b1;
        end
    end

    // Sample state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q  <= '0;
            tripped_q <= 1'b0;
            no_trip_q <= 1'b0;
        end else begin
            sample_q  <= sample_d;
            tripped_q <= tripped_d;
            no_trip_q <= no_trip_d;
        end
    end

    assign sample  = sample_q;
    assign no_trip = no_trip_q;

endmodule

// File: rtl/pixel_sensor_cds.sv
// Single-pixel digital back end: erase / expose / ramp conversion control,
// first-trip sampling of the global ramp code and a registered readout that
// drives zero when not selected so many pixels can be wire-ORed.
// Build option: define PIXEL_SENSOR_CDS_EN to add the reset-level conversion
// window, its sample register and the clamped subtractor (correlated double
// sampling). Without it the pixel reports the signal sample directly.
module pixel_sensor_cds
    import PixelSensorConfig::*;
#(
    parameter int PIXEL_BITS   = PIXEL_BITS_DEFAULT,
    parameter int WIDTH_INDEX  = 0,
    parameter int HEIGHT_INDEX = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ERASE,
    input  logic                  EXPOSE,
    input  logic                  CONVERT,
    input  logic                  READ,
    input  logic                  CMP,
    input  logic [PIXEL_BITS-1:0] COUNTER,
    output logic [PIXEL_BITS-1:0] DATA,
    output logic                  DATA_VALID,
    output logic                  OVERFLOW
);

    // The array position parameters only identify the instance; reject
    // nonsensical values and unsupported widths at elaboration
    if (PIXEL_BITS < PIXEL_BITS_MIN || PIXEL_BITS > PIXEL_BITS_MAX ||
        WIDTH_INDEX < 0 || HEIGHT_INDEX < 0) begin : g_bad_param
        $error("pixel_sensor_cds: unsupported parameter value");
    end

    pixel_state_t          state_q;
    pixel_state_t          state_d;
    logic                  convert_q;
    logic                  convert_d;
    logic                  convert_fall;
    logic [PIXEL_BITS-1:0] data_q;
    logic [PIXEL_BITS-1:0] data_d;
    logic                  data_valid_q;
    logic                  data_valid_d;

    logic                  sig_open;
    logic                  sig_close;
    logic [PIXEL_BITS-1:0] sig_sample;
    logic                  sig_no_trip;
    logic [PIXEL_BITS-1:0] result;

`ifdef PIXEL_SENSOR_CDS_EN
    logic                  rst_open;
    logic                  rst_close;
    logic [PIXEL_BITS-1:0] rst_sample;
    logic                  rst_no_trip;
    logic [PIXEL_BITS:0]   diff_wide;
`endif

    // Remember CONVERT so a window ends on its falling edge rather than on
    // a low level, which lets CONV_SIG wait for its own rising edge
    always_comb begin
        convert_d    = CONVERT;
        convert_fall = convert_q && !CONVERT;
    end

    // Next-state logic; ERASE overrides every other input in every state
    always_comb begin
        state_d = state_q;
        if (ERASE) begin
            state_d = ST_ERASE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ERASE: begin
                    if (EXPOSE) begin
                        state_d = ST_EXPOSE;
                    end
                end
                ST_EXPOSE: begin
                    if (!EXPOSE && CONVERT) begin
`ifdef PIXEL_SENSOR_CDS_EN
                        state_d = ST_CONV_RST;
`else
                        state_d = ST_CONV_SIG;
`endif
                    end
                end
`ifdef PIXEL_SENSOR_CDS_EN
                ST_CONV_RST: begin
                    if (convert_fall) begin
                        state_d = ST_CONV_SIG;
                    end
                end
`endif
                ST_CONV_SIG: begin
                    if (convert_fall) begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    state_d = ST_HOLD;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Conversion windows are open only while CONVERT is high in their state
    always_comb begin
        sig_open  = (state_q == ST_CONV_SIG) && CONVERT;
        sig_close = (state_q == ST_CONV_SIG) && convert_fall;
`ifdef PIXEL_SENSOR_CDS_EN
        rst_open  = (state_q == ST_CONV_RST) && CONVERT;
        rst_close = (state_q == ST_CONV_RST) && convert_fall;
`endif
    end

    pixel_sample_latch #(
        .PIXEL_BITS (PIXEL_BITS)
    ) u_sig_latch (
        .clk          (clk),
        .reset        (reset),
        .clear        (ERASE),
        .window_open  (sig_open),
        .window_close (sig_close),
        .cmp          (CMP),
        .counter      (COUNTER),
        .sample       (sig_sample),
        .no_trip      (sig_no_trip)
    );

`ifdef PIXEL_SENSOR_CDS_EN
    pixel_sample_latch #(
        .PIXEL_BITS (PIXEL_BITS)
    ) u_rst_latch (
        .clk          (clk),
        .reset        (reset),
        .clear        (ERASE),
        .window_open  (rst_open),
        .window_close (rst_close),
        .cmp          (CMP),
        .counter      (COUNTER),
        .sample       (rst_sample),
        .no_trip      (rst_no_trip)
    );
`endif

    // Pixel value: signal minus reset level with an extra sign bit, clamped
    // at zero when the reset level is the larger of the two
    always_comb begin
`ifdef PIXEL_SENSOR_CDS_EN
        diff_wide = {1'b0, sig_sample} - {1'b0, rst_sample};
        if (diff_wide[PIXEL_BITS]) begin
            result = '0;
        end else begin
            result = diff_wide[PIXEL_BITS-1:0];
        end
`else
        result = sig_sample;
`endif
    end

    // Readout drives the value only for a READ in HOLD, zero otherwise
    always_comb begin
        data_d       = '0;
        data_valid_d = 1'b0;
        if (!ERASE && (state_q == ST_HOLD) && READ) begin
            data_d       = result;
            data_valid_d = 1'b1;
        end
    end

    // Control and readout registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            convert_q    <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            convert_q    <= convert_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign DATA       = data_q;
    assign DATA_VALID = data_valid_q;
`ifdef PIXEL_SENSOR_CDS_EN
    assign OVERFLOW   = sig_no_trip || rst_no_trip;
`else
    assign OVERFLOW   = sig_no_trip;
`endif

endmodule
